// File: rtl/edge_det_multi.sv
// Multi-channel edge detector: synchroniser, per-channel mode, pulse, sticky, counter, irq.
// Optional debounce filter on each channel is enabled by defining EDGE_DEBOUNCE_EN.
module edge_det_multi #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int FILT_CYC    = 4,
    localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_CH-1:0]   din,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clr,
    input  logic [N_CH-1:0]   irq_mask,
    input  logic [SEL_W-1:0]  cnt_sel,
    output logic [N_CH-1:0]   pulse,
    output logic [N_CH-1:0]   sticky,
    output logic [CNT_W-1:0]  cnt_rd,
    output logic              irq
);

    logic [N_CH-1:0]  s;
    logic [N_CH-1:0]  l;
    logic [N_CH-1:0]  prev;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  fall;
    logic [N_CH-1:0]  ev;
    logic [CNT_W-1:0] cnt_q [N_CH];

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = din;
        end else begin : g_sync
            logic [N_CH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= din;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

`ifdef EDGE_DEBOUNCE_EN
    localparam int FW = $clog2(FILT_CYC + 1);

    logic [N_CH-1:0] filt_q;
    logic [FW-1:0]   stab_q [N_CH];

    // The filtered level follows s only after FILT_CYC consecutive mismatches.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                stab_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (s[i] != filt_q[i]) begin
                    if (stab_q[i] == FW'(FILT_CYC - 1)) begin
                        filt_q[i] <= s[i];
                        stab_q[i] <= '0;
                    end else begin
                        stab_q[i] <= stab_q[i] + FW'(1);
                    end
                end else begin
                    stab_q[i] <= '0;
                end
            end
        end
    end

    assign l = filt_q;
`else
    assign l = s;
`endif

    assign rise = l & ~prev;
    assign fall = ~l & prev;

    always_comb begin
        ev = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (mode[2*i +: 2])
                2'b01:   ev[i] = rise[i];
                2'b10:   ev[i] = fall[i];
                2'b11:   ev[i] = rise[i] | fall[i];
                default: ev[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev   <= '0;
            pulse  <= '0;
            sticky <= '0;
            irq    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            prev   <= l;
            pulse  <= ev;
            sticky <= ev | (sticky & ~clr);
            irq    <= |(sticky & irq_mask);
            // A clear coinciding with an event leaves a count of one.
            for (int i = 0; i < N_CH; i++) begin
                if (clr[i]) begin
                    cnt_q[i] <= ev[i] ? CNT_W'(1) : '0;
                end else if (ev[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_rd = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cnt_sel == i[SEL_W-1:0]) begin
                cnt_rd = cnt_q[i];
            end
        end
    end

endmodule

// File: doc/edge_det_multi.md
Name: edge_det_multi

Overview:
Multi-channel, mode-programmable edge detector. It is the parametrised successor of the single-channel rising-edge detector FSM.
- Each channel synchronises an asynchronous level input and detects rising, falling or both edges, per channel.
- Each channel emits a one-cycle registered pulse, a sticky flag and a saturating event count.
- Sits between raw GPIO/status lines and the interrupt/status register block.

Parameters:
N_CH, 8, number of independent input channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (0 = input already synchronous)
CNT_W, 8, width of each per-channel saturating event counter
FILT_CYC, 4, debounce stability window in clk cycles (used only with EDGE_DEBOUNCE_EN; 1..2^16)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
din  in  N_CH  raw level inputs, bit i = channel i
mode  in  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr  in  N_CH  per-channel clear of sticky flag and counter (synchronous, level)
irq_mask  in  N_CH  1 = channel contributes to irq
cnt_sel  in  $clog2(N_CH) (min 1)  channel index for cnt_rd
pulse  out  N_CH  registered one-cycle edge pulse per channel
sticky  out  N_CH  latched event flag per channel
cnt_rd  out  CNT_W  event count of channel cnt_sel (combinational mux of registers)
irq  out  1  registered OR of (sticky & irq_mask)

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. While rstn=0, all of the following are 0: sync flops, level history (prev), pulse, sticky, counters, irq. Release is synchronous to clk at the flop level.
- Per-channel datapath:
  - din[i] passes through SYNC_STAGES flops, giving s[i]. With SYNC_STAGES=0, s[i]=din[i].
  - l[i] = s[i], or the filtered level when debounce is compiled in.
  - prev[i] <= l[i] every cycle.
- Edge terms:
  - rise = l & ~prev
  - fall = ~l & prev
  - ev = (mode==01 & rise) | (mode==10 & fall) | (mode==11 & (rise|fall)); mode==00 gives ev=0.
- pulse[i] <= ev[i].
- Latency: din change sampled at edge k gives pulse high in the cycle after edge k+SYNC_STAGES. That is SYNC_STAGES+1 clocks; pulse lasts exactly 1 cycle.
- Input held high through reset release produces one rise event, because prev resets to 0.
- Input toggling every cycle (SYNC_STAGES≥0, mode 11) produces a pulse every cycle.
- Mode change: takes effect on the next evaluated cycle. A mode change alone never generates a pulse. prev keeps tracking l in all modes, including 00.
- sticky[i]:
  - set by ev[i] (same edge pulse is set);
  - cleared by clr[i];
  - simultaneous ev and clr: ev wins, sticky=1.
- Counter[i]:
  - increments by 1 on ev[i] and saturates at 2^CNT_W-1 (no wrap);
  - clr[i] sets it to 0;
  - simultaneous ev and clr loads 1.
- irq <= |(sticky & irq_mask), so it is 1 cycle behind sticky. Masking does not affect sticky or counters.
- cnt_sel ≥ N_CH returns cnt_rd=0.
- Reset mid-operation: everything returns to reset values immediately. No pulse is generated for edges pending in the synchroniser.

Optional Feature:
EDGE_DEBOUNCE_EN
- Defined:
  - Each channel gets a filtered level f[i] (reset 0) and a stability counter (reset 0).
  - While s!=f the counter increments each cycle. When s==f it resets to 0.
  - On the FILT_CYC-th consecutive mismatch edge, f<=s and the counter resets.
  - l=f. Added latency is FILT_CYC cycles.
  - Glitches shorter than FILT_CYC cycles produce no pulse.
- Not defined: l=s, no filter logic, FILT_CYC ignored.

Test Plan:
1. Reset release with din=8'h00, mode=all 01, then din[0] 0->1 at edge k (SYNC_STAGES=2) -> pulse[0] high only in the cycle after edge k+2. sticky[0]=1 from the same point; cnt of ch0=1; irq=1 one cycle later if irq_mask[0]=1.
2. Modes: ch1=01, ch2=10, ch3=11, ch4=00; drive din[4:1] 0->1 then 1->0, 10 cycles apart:
   - ch1 pulses once (rise);
   - ch2 pulses once (fall);
   - ch3 pulses twice;
   - ch4 never pulses, and its sticky and count stay 0.
3. CNT_W=3, mode 11, toggle din[5] 10 times -> count saturates at 7; sticky[5]=1. Assert clr[5] on the same cycle as an event -> count=1, sticky=1. Clear with no event -> 0/0.
4. Hold din[6]=1 through reset, deassert rstn, mode 01 -> exactly one pulse[6], SYNC_STAGES+1 cycles after the first clk edge.
5. With EDGE_DEBOUNCE_EN, FILT_CYC=4:
   - a 3-cycle high glitch on din[7] -> no pulse;
   - a 4-cycle-stable high -> one pulse, SYNC_STAGES+4+1 cycles after the first sampling edge.
6. Assert rstn low while pulse[2] is high and a din edge is in the synchroniser -> all outputs 0 immediately. After release, with din stable low, no pulse.
